// File: rtl/fp_div_pkg.sv
// Shared types and helpers for the fixed-point divider issue stage.
// Holds the control-state encoding and the divide-by-zero result pattern.
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int div_iters(input int width, input int frac_width);
        return width + frac_width;
    endfunction

    // Iteration count of the divider in its default 4-bit Q2.2 configuration.
    localparam int DIV_ITERS = div_iters(4, 2);

    function automatic logic [63:0] dbz_quotient(input int width);
        return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/fp_div_req_fifo.sv
// Two-entry request FIFO; head is always the oldest stored entry.
// Push into a full FIFO and pop from an empty one are ignored.
module fp_div_req_fifo
    import fp_div_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          push_ok, pop_ok;

    always_comb begin
        push_ok  = push && (count_q != 2'd2);
        pop_ok   = pop && (count_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push_ok;
        rd_ptr_d = rd_ptr_q ^ pop_ok;
        count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: count gates every use of it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fp_div_issue.sv
// Issue/collect stage in front of a go/done fixed-point divider: queues requests,
// sequences the divider, short-circuits divide-by-zero and times out a hung divider.
module fp_div_issue
    import fp_div_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int INT_WIDTH  = 2,
    parameter int FRAC_WIDTH = 2,
    parameter int WDOG_SLACK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    output logic             div_go,
    output logic [WIDTH-1:0] div_left,
    output logic [WIDTH-1:0] div_right,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_dbz,
    output logic             out_timeout
);

    localparam int ITERS = div_iters(WIDTH, FRAC_WIDTH);
    localparam int LIMIT = ITERS + WDOG_SLACK;
    localparam int WD_W  = $clog2(LIMIT + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(LIMIT - 1);
    localparam logic [WIDTH-1:0] DBZ_Q   = WIDTH'(dbz_quotient(WIDTH));

    if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_fmt_check
        $error("fp_div_issue: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
    end

    state_t              state_q, state_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [WIDTH-1:0]    quot_q, quot_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic                dbz_q, dbz_d;
    logic                to_q, to_d;

    logic [2*WIDTH-1:0]  fifo_head;
    logic [1:0]          fifo_count;
    logic                fifo_push, fifo_pop;
    logic [WIDTH-1:0]    head_left, head_right;

    assign in_ready   = (fifo_count != 2'd2);
    assign fifo_push  = in_valid && in_ready;
    assign head_left  = fifo_head[2*WIDTH-1:WIDTH];
    assign head_right = fifo_head[WIDTH-1:0];

    fp_div_req_fifo #(
        .DW (2*WIDTH)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({in_left, in_right}),
        .head  (fifo_head),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        wdog_d   = wdog_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        to_d     = to_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_count != 2'd0) begin
                    if (head_right != '0) begin
                        state_d = RUN;
                        wdog_d  = '0;
                    end else begin
                        // Divide-by-zero never reaches the divider.
                        fifo_pop = 1'b1;
                        state_d  = HOLD;
                        quot_d   = DBZ_Q;
                        rem_d    = head_left;
                        dbz_d    = 1'b1;
                        to_d     = 1'b0;
                    end
                end
            end
            RUN: begin
                wdog_d = wdog_q + 1'b1;
                if (div_done) begin
                    fifo_pop = 1'b1;
                    state_d  = HOLD;
                    quot_d   = div_quotient;
                    rem_d    = div_remainder;
                    dbz_d    = 1'b0;
                    to_d     = 1'b0;
                end else if (wdog_q == WD_LAST) begin
                    fifo_pop = 1'b1;
                    state_d  = HOLD;
                    quot_d   = '0;
                    rem_d    = '0;
                    dbz_d    = 1'b0;
                    to_d     = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wdog_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            to_q    <= to_d;
        end
    end

    // Go falls in the done cycle so the divider cannot re-arm on the same operands.
    assign div_go        = (state_q == RUN) && !div_done && !reset;
    assign div_left      = head_left;
    assign div_right     = head_right;
    assign out_valid     = (state_q == HOLD);
    assign out_quotient  = quot_q;
    assign out_remainder = rem_q;
    assign out_dbz       = dbz_q;
    assign out_timeout   = to_q;

endmodule

// File: tb/tb_fp_div_issue.sv
// Bench for fp_div_issue: behavioural go/done divider plus an expected-result queue
// built from the arithmetic rules, with directed and randomized requests.
module tb_fp_div_issue;

    localparam int W  = 4;
    localparam int FW = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready;
    logic [W-1:0] in_left, in_right;
    logic         div_go, div_done;
    logic [W-1:0] div_left, div_right, div_quotient, div_remainder;
    logic         out_valid, out_ready;
    logic [W-1:0] out_quotient, out_remainder;
    logic         out_dbz, out_timeout;

    always #5 clk = ~clk;

    fp_div_issue #(
        .WIDTH      (W),
        .INT_WIDTH  (2),
        .FRAC_WIDTH (FW),
        .WDOG_SLACK (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_left       (in_left),
        .in_right      (in_right),
        .div_go        (div_go),
        .div_left      (div_left),
        .div_right     (div_right),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_dbz       (out_dbz),
        .out_timeout   (out_timeout)
    );

    function automatic logic [W-1:0] f_quot(input logic [W-1:0] l, input logic [W-1:0] r);
        int n;
        n = int'(l) << FW;
        return W'(n / int'(r));
    endfunction

    function automatic logic [W-1:0] f_rem(input logic [W-1:0] l, input logic [W-1:0] r);
        int n;
        n = int'(l) << FW;
        return W'(n % int'(r));
    endfunction

    // Behavioural divider: zero dividend finishes in 1 cycle, others in W+FW+2.
    logic         m_busy, m_done, hang, spur;
    int           m_cnt;
    logic [W-1:0] m_l, m_r, m_q, m_rem;
    assign div_done      = m_done | spur;
    assign div_quotient  = m_q;
    assign div_remainder = m_rem;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_q    <= '0;
            m_rem  <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (!div_go) begin
                    m_busy <= 1'b0;
                end else if (m_cnt <= 1 && !hang) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_q    <= f_quot(m_l, m_r);
                    m_rem  <= f_rem(m_l, m_r);
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (div_go) begin
                m_busy <= 1'b1;
                m_cnt  <= (div_left == '0) ? 1 : W + FW + 2;
                m_l    <= div_left;
                m_r    <= div_right;
            end
        end
    end

    // Go-protocol monitor.
    int           go_windows = 0, go_cycles = 0, go_done_overlap = 0, op_unstable = 0;
    logic         go_prev = 1'b0;
    logic [W-1:0] l_prev = '0, r_prev = '0;
    always @(negedge clk) begin
        if (div_go && !go_prev) go_windows++;
        if (div_go) go_cycles++;
        if (div_go && div_done) go_done_overlap++;
        if (div_go && go_prev && (div_left != l_prev || div_right != r_prev)) op_unstable++;
        go_prev = div_go;
        l_prev  = div_left;
        r_prev  = div_right;
    end

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         to;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
        int   t;
        exp_t e;
        t = 0;
        while (!in_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", in_ready, 1);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        @(negedge clk);
        in_valid = 1'b0;
        if (r == '0) begin
            e.q = '1; e.r = l; e.dbz = 1'b1; e.to = 1'b0;
        end else if (hang) begin
            e.q = '0; e.r = '0; e.dbz = 1'b0; e.to = 1'b1;
        end else begin
            e.q = f_quot(l, r); e.r = f_rem(l, r); e.dbz = 1'b0; e.to = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input string tag);
        int t;
        t = 0;
        while (!out_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk(tag, out_valid, 1);
    endtask

    task automatic pop_result(input string tag, input int stall);
        exp_t e;
        wait_valid({tag, "_valid"});
        chk({tag, "_pending"}, (exp_q.size() > 0), 1);
        if (out_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            repeat (stall) @(negedge clk);
            chk({tag, "_quot"}, out_quotient, e.q);
            chk({tag, "_rem"}, out_remainder, e.r);
            chk({tag, "_dbz"}, out_dbz, e.dbz);
            chk({tag, "_to"}, out_timeout, e.to);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int           w0, t;
        logic [W-1:0] hq, l, r;

        reset = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0;
        out_ready = 1'b0; hang = 1'b0; spur = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quot", out_quotient, 0);
        chk("rst_rem", out_remainder, 0);
        chk("rst_dbz", out_dbz, 0);
        chk("rst_to", out_timeout, 0);
        chk("rst_go", div_go, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // 2.0 / 1.0
        w0 = go_windows;
        push(4'b1000, 4'b0100);
        chk("lat_go_low", div_go, 0);
        @(negedge clk);
        chk("lat_go_high", div_go, 1);
        pop_result("div_2_1", 0);
        chk("div_2_1_quot_const", out_quotient, 4'b1000);
        chk("div_2_1_windows", go_windows - w0, 1);

        // 1.5 / 0.5 = 3.0
        push(4'b0110, 4'b0010);
        pop_result("div_15_05", 1);

        // Divide by zero: no divider start, result within 2 cycles.
        w0 = go_windows;
        push(4'b0101, 4'b0000);
        @(negedge clk);
        chk("dbz_fast_valid", out_valid, 1);
        pop_result("dbz", 0);
        chk("dbz_no_go", go_windows - w0, 0);

        // Zero dividend takes the divider's short path.
        push(4'b0000, 4'b0011);
        pop_result("zero_left", 0);

        // Spurious done outside RUN.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_valid0", out_valid, 0);
        @(negedge clk);
        chk("spur_valid1", out_valid, 0);

        // Back-to-back with a stalled consumer.
        push(4'b1010, 4'b0011);
        push(4'b0111, 4'b0101);
        chk("b2b_full", in_ready, 0);
        chk("b2b_inflight", div_go, 1);
        push(4'b1100, 4'b0110);
        wait_valid("b2b_hold_valid");
        hq = out_quotient;
        repeat (4) @(negedge clk);
        chk("b2b_hold_stable_q", out_quotient, hq);
        chk("b2b_hold_stable_v", out_valid, 1);
        pop_result("b2b_a", 0);
        pop_result("b2b_b", 0);
        pop_result("b2b_c", 0);

        // Hung divider -> watchdog.
        hang = 1'b1;
        go_cycles = 0;
        push(4'b0111, 4'b0011);
        wait_valid("wd_valid");
        chk("wd_go_low", div_go, 0);
        chk("wd_go_cycles", go_cycles, 10);
        pop_result("wd", 0);
        hang = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 10; i++) begin
            l = W'($urandom_range(0, 15));
            r = ($urandom_range(0, 3) == 0) ? 4'b0000 : W'($urandom_range(1, 15));
            push(l, r);
            pop_result("rand", $urandom_range(0, 3));
        end

        // Reset in the middle of RUN.
        push(4'b1000, 4'b0100);
        t = 0;
        while (!div_go && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("mid_go_seen", div_go, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_go", div_go, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        reset = 1'b0;
        exp_q.delete();
        w0 = go_windows;
        repeat (3) @(negedge clk);
        chk("mid_rst_empty", go_windows - w0, 0);
        push(4'b0011, 4'b0001);
        pop_result("post_rst", 0);

        chk("go_low_in_done", go_done_overlap, 0);
        chk("ops_stable", op_unstable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
